core_fetch_queue: RTL and testbench

- Parametrised successor to the core fetch unit.
- Issues sequential word fetches to the memory port, tracks up to MAX_PENDING outstanding requests and buffers returned words with their PCs in a 2^ORDER-entry FIFO.
- Presents the FIFO head to decode.
- On flush it redirects to target, empties the FIFO, and discards in-flight responses from the old stream by count, not by waiting.

---
 rtl/core_fetch_queue_pkg.sv | 20 ++
 rtl/core_fetch_queue_if.sv | 27 ++
 rtl/core_fetch_fifo.sv | 49 ++++
 rtl/core_fetch_queue.sv | 112 +++++++++++
 tb/tb_core_fetch_queue.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/core_fetch_queue_pkg.sv
// Shared types for the fetch queue: address/data words, pending counters
// and the buffered fetch entry.
package core_fetch_queue_pkg;

    localparam int unsigned PTR_W             = 16;
    localparam int unsigned WORD_W            = 32;
    // Largest MAX_PENDING any instance may use; sizes fetch_count_t.
    localparam int unsigned FETCH_PENDING_MAX = 8;

    typedef logic [PTR_W-1:0]  ptr;
    typedef logic [WORD_W-1:0] word;

    typedef logic [$clog2(FETCH_PENDING_MAX + 1)-1:0] fetch_count_t;

    typedef struct packed {
        word data;
        ptr  pc;
    } fetch_entry_t;

endpackage

// File: rtl/core_fetch_queue_if.sv
// Memory-port and decode-side signals of the fetch queue.
interface core_fetch_queue_if;
    import core_fetch_queue_pkg::*;

    logic stall;
    logic flush;
    ptr   target;
    logic fetch;
    logic fetch_ack;
    logic fetched;
    word  fetch_data;
    ptr   addr;
    logic insn_valid;
    word  insn;
    ptr   insn_pc;

    modport master (
        input  stall, flush, target, fetch_ack, fetched, fetch_data,
        output fetch, addr, insn_valid, insn, insn_pc
    );

    modport slave (
        output stall, flush, target, fetch_ack, fetched, fetch_data,
        input  fetch, addr, insn_valid, insn, insn_pc
    );

endinterface

// File: rtl/core_fetch_fifo.sv
// Synchronous FIFO of 2^ORDER entries with push, pop and clear; the extra
// pointer bit distinguishes full from empty.
module core_fetch_fifo
    import core_fetch_queue_pkg::*;
#(
    parameter int unsigned ORDER = 2,
    parameter type         T     = fetch_entry_t
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           push,
    input  T               din,
    input  logic           pop,
    output T               head,
    output logic           empty,
    output logic [ORDER:0] count
);

    localparam int unsigned    DEPTH   = 1 << ORDER;
    localparam logic [ORDER:0] PTR_ONE = (ORDER + 1)'(1);

    T               mem [DEPTH];
    logic [ORDER:0] wr_ptr;
    logic [ORDER:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[ORDER-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage carries no reset; occupancy is governed by the pointers.
    always_ff @(posedge clk) begin
        if (push && !rst && !clear)
            mem[wr_ptr[ORDER-1:0]] <= din;
    end

endmodule

// File: rtl/core_fetch_queue.sv
// Sequential instruction fetch with credit-limited issue, response buffering
// and count-based discard of stale responses after a redirect.
module core_fetch_queue
    import core_fetch_queue_pkg::*;
#(
    parameter int unsigned ORDER       = 2,
    parameter int unsigned MAX_PENDING = 2,
    parameter ptr          RESET_PC    = '0
) (
    input  logic               clk,
    input  logic               rst,
    core_fetch_queue_if.master bus
);

    localparam int unsigned DEPTH = 1 << ORDER;
    localparam int unsigned CNT_W = $bits(fetch_count_t);
    // Wide enough for count + pending without overflow.
    localparam int unsigned CW    = ((ORDER + 1) > CNT_W ? (ORDER + 1) : CNT_W) + 1;

    localparam fetch_count_t    MAX_P   = fetch_count_t'(MAX_PENDING);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    ptr           addr_q;
    ptr           addr_d;
    ptr           resp_pc_q;
    ptr           resp_pc_d;
    fetch_count_t pending_q;
    fetch_count_t pending_d;
    fetch_count_t discard_q;
    fetch_count_t discard_d;

    logic           fetch_c;
    logic           ack_c;
    logic           push_c;
    logic           pop_c;
    logic           insn_valid_c;
    logic [CW-1:0]  in_flight_c;

    fetch_entry_t   push_entry;
    fetch_entry_t   head;
    logic           empty;
    logic [ORDER:0] count;

    assign push_entry = '{data: bus.fetch_data, pc: resp_pc_q};

    core_fetch_fifo #(
        .ORDER (ORDER),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.flush),
        .push  (push_c),
        .din   (push_entry),
        .pop   (pop_c),
        .head  (head),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= RESET_PC;
            resp_pc_q <= RESET_PC;
            pending_q <= '0;
            discard_q <= '0;
        end else begin
            addr_q    <= addr_d;
            resp_pc_q <= resp_pc_d;
            pending_q <= pending_d;
            discard_q <= discard_d;
        end
    end

    // Issue credit, response routing and redirect bookkeeping.
    always_comb begin
        addr_d       = addr_q;
        resp_pc_d    = resp_pc_q;
        pending_d    = pending_q;
        discard_d    = discard_q;

        in_flight_c  = CW'(count) + CW'(pending_q) - CW'(discard_q);
        fetch_c      = !rst && !bus.flush && (pending_q < MAX_P) && (in_flight_c < DEPTH_C);
        ack_c        = fetch_c && bus.fetch_ack;
        push_c       = bus.fetched && !bus.flush && (discard_q == '0);
        insn_valid_c = !rst && !empty;
        pop_c        = insn_valid_c && !bus.stall;

        if (bus.flush) begin
            // Everything still outstanding belongs to the old stream.
            addr_d    = bus.target;
            resp_pc_d = bus.target;
            pending_d = pending_q - fetch_count_t'(bus.fetched);
            discard_d = pending_q - fetch_count_t'(bus.fetched);
        end else begin
            if (ack_c)
                addr_d = addr_q + ptr'(1);
            if (push_c)
                resp_pc_d = resp_pc_q + ptr'(1);
            pending_d = pending_q + fetch_count_t'(ack_c) - fetch_count_t'(bus.fetched);
            if (bus.fetched && (discard_q != '0))
                discard_d = discard_q - fetch_count_t'(1);
        end
    end

    assign bus.fetch      = fetch_c;
    assign bus.addr       = addr_q;
    assign bus.insn_valid = insn_valid_c;
    assign bus.insn       = head.data;
    assign bus.insn_pc    = head.pc;

endmodule

// File: tb/tb_core_fetch_queue.sv
// Directed bench for core_fetch_queue: a small memory model answers acked
// requests one cycle later with data = addr ^ 0xAAAA.
module tb_core_fetch_queue;
    import core_fetch_queue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_fetch_queue_if bus_a ();
    core_fetch_queue_if bus_b ();

    core_fetch_queue #(.ORDER(2), .MAX_PENDING(2), .RESET_PC(16'h0100)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    core_fetch_queue #(.ORDER(2), .MAX_PENDING(2), .RESET_PC(16'hFFFF)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    typedef struct {
        ptr a;
        int c;
    } req_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   nacks  = 0;
    req_t q[$];
    ptr   pop_pc[$];
    word  pop_data[$];
    logic last_fetch;
    ptr   last_addr;

    function automatic word exp_data(input ptr p);
        return word'(p) ^ 32'h0000_AAAA;
    endfunction

    task automatic idle_inputs();
        bus_a.stall = 0; bus_a.flush = 0; bus_a.target = '0;
        bus_a.fetch_ack = 0; bus_a.fetched = 0; bus_a.fetch_data = '0;
        bus_b.stall = 0; bus_b.flush = 0; bus_b.target = '0;
        bus_b.fetch_ack = 0; bus_b.fetched = 0; bus_b.fetch_data = '0;
    endtask

    // One cycle on dut_a: respond from the model, ack if allowed, log pops.
    task automatic tick(input logic st, input logic fl, input ptr tg,
                        input logic ack_en, input logic rsp_en);
        @(negedge clk);
        bus_a.stall = st; bus_a.flush = fl; bus_a.target = tg;
        bus_a.fetched = 0; bus_a.fetch_data = '0;
        if (rsp_en && q.size() > 0 && q[0].c < cyc) begin
            bus_a.fetched    = 1;
            bus_a.fetch_data = exp_data(q[0].a);
            void'(q.pop_front());
        end
        #1;
        last_fetch      = bus_a.fetch;
        last_addr       = bus_a.addr;
        bus_a.fetch_ack = ack_en && bus_a.fetch;
        if (bus_a.fetch_ack) begin
            q.push_back('{a: bus_a.addr, c: cyc});
            nacks++;
        end
        if (bus_a.insn_valid && !st && !fl) begin
            pop_pc.push_back(bus_a.insn_pc);
            pop_data.push_back(bus_a.insn);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        idle_inputs();
        q.delete(); pop_pc.delete(); pop_data.delete();
        nacks = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        idle_inputs();
        #1;
        checks++; if (bus_a.fetch !== 1'b0) begin errors++; $display("FAIL reset_fetch: got %b want 0", bus_a.fetch); end
        checks++; if (bus_a.insn_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus_a.insn_valid); end
        @(posedge clk); #1;
        checks++; if (bus_a.addr !== 16'h0100) begin errors++; $display("FAIL reset_addr_a: got %h want 0100", bus_a.addr); end
        checks++; if (bus_b.addr !== 16'hFFFF) begin errors++; $display("FAIL reset_addr_b: got %h want ffff", bus_b.addr); end
        checks++; if (bus_b.fetch !== 1'b0) begin errors++; $display("FAIL reset_fetch_b: got %b want 0", bus_b.fetch); end
        @(negedge clk);
        rst = 0;
        #1;
        checks++; if (bus_a.fetch !== 1'b1) begin errors++; $display("FAIL post_reset_fetch: got %b want 1", bus_a.fetch); end
        checks++; if (bus_a.insn_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", bus_a.insn_valid); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 12; i++) tick(0, 0, '0, 1, 1);
        for (int i = 0; i < 3; i++)  tick(0, 0, '0, 0, 1);
        checks++; if (pop_pc.size() !== 12) begin errors++; $display("FAIL stream_count: got %0d want 12", pop_pc.size()); end
        for (int i = 0; i < pop_pc.size() && i < 12; i++) begin
            checks++; if (pop_pc[i] !== ptr'(32'h100 + i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, pop_pc[i], ptr'(32'h100 + i)); end
            checks++; if (pop_data[i] !== exp_data(ptr'(32'h100 + i))) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, pop_data[i], exp_data(ptr'(32'h100 + i))); end
        end
        checks++; if (bus_a.addr !== 16'h010C) begin errors++; $display("FAIL stream_addr: got %h want 010c", bus_a.addr); end
        checks++; if (bus_a.insn_valid !== 1'b0) begin errors++; $display("FAIL stream_drained: got %b want 0", bus_a.insn_valid); end
    endtask

    task automatic test_stall_full();
        do_reset();
        for (int i = 0; i < 8; i++) tick(1, 0, '0, 1, 1);
        checks++; if (last_fetch !== 1'b0) begin errors++; $display("FAIL full_fetch: got %b want 0", last_fetch); end
        checks++; if (nacks !== 4) begin errors++; $display("FAIL full_acks: got %0d want 4", nacks); end
        checks++; if (bus_a.addr !== 16'h0104) begin errors++; $display("FAIL full_addr: got %h want 0104", bus_a.addr); end
        checks++; if (bus_a.insn_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", bus_a.insn_valid); end
        checks++; if (bus_a.insn_pc !== 16'h0100) begin errors++; $display("FAIL full_head: got %h want 0100", bus_a.insn_pc); end
        tick(0, 0, '0, 1, 1);
        checks++; if (last_fetch !== 1'b0) begin errors++; $display("FAIL pop_cycle_fetch: got %b want 0", last_fetch); end
        tick(1, 0, '0, 1, 1);
        checks++; if (last_fetch !== 1'b1) begin errors++; $display("FAIL refetch: got %b want 1", last_fetch); end
        checks++; if (last_addr !== 16'h0104) begin errors++; $display("FAIL refetch_addr: got %h want 0104", last_addr); end
        checks++; if (pop_pc.size() !== 1) begin errors++; $display("FAIL full_pops: got %0d want 1", pop_pc.size()); end
        checks++; if (bus_a.insn_pc !== 16'h0101) begin errors++; $display("FAIL full_next_head: got %h want 0101", bus_a.insn_pc); end
    endtask

    task automatic test_flush_pending();
        do_reset();
        tick(0, 1, 16'h0010, 1, 1);
        tick(0, 0, '0, 1, 0);
        tick(0, 0, '0, 1, 0);
        checks++; if (nacks !== 2) begin errors++; $display("FAIL fp_acks: got %0d want 2", nacks); end
        tick(0, 1, 16'h0040, 1, 0);
        checks++; if (last_fetch !== 1'b0) begin errors++; $display("FAIL fp_flush_fetch: got %b want 0", last_fetch); end
        tick(0, 0, '0, 1, 1);
        checks++; if (last_fetch !== 1'b0) begin errors++; $display("FAIL fp_credit_fetch: got %b want 0", last_fetch); end
        checks++; if (bus_a.insn_valid !== 1'b0) begin errors++; $display("FAIL fp_drop1: got %b want 0", bus_a.insn_valid); end
        tick(0, 0, '0, 1, 1);
        checks++; if (last_addr !== 16'h0040) begin errors++; $display("FAIL fp_target_addr: got %h want 0040", last_addr); end
        checks++; if (bus_a.insn_valid !== 1'b0) begin errors++; $display("FAIL fp_drop2: got %b want 0", bus_a.insn_valid); end
        tick(0, 0, '0, 1, 1);
        checks++; if (last_addr !== 16'h0041) begin errors++; $display("FAIL fp_addr_after_ack: got %h want 0041", last_addr); end
        tick(0, 0, '0, 0, 1);
        tick(0, 0, '0, 0, 1);
        checks++; if (pop_pc.size() !== 2) begin errors++; $display("FAIL fp_pops: got %0d want 2", pop_pc.size()); end
        if (pop_pc.size() >= 2) begin
            checks++; if (pop_pc[0] !== 16'h0040) begin errors++; $display("FAIL fp_first_pc: got %h want 0040", pop_pc[0]); end
            checks++; if (pop_data[0] !== 32'h0000_AAEA) begin errors++; $display("FAIL fp_first_data: got %h want 0000aaea", pop_data[0]); end
            checks++; if (pop_pc[1] !== 16'h0041) begin errors++; $display("FAIL fp_second_pc: got %h want 0041", pop_pc[1]); end
        end
    endtask

    task automatic test_flush_fetched();
        do_reset();
        tick(0, 0, '0, 1, 0);
        tick(0, 0, '0, 1, 0);
        tick(0, 1, 16'h0200, 1, 1);
        checks++; if (last_fetch !== 1'b0) begin errors++; $display("FAIL ff_flush_fetch: got %b want 0", last_fetch); end
        checks++; if (bus_a.insn_valid !== 1'b0) begin errors++; $display("FAIL ff_empty: got %b want 0", bus_a.insn_valid); end
        tick(1, 0, '0, 1, 1);
        checks++; if (last_fetch !== 1'b1) begin errors++; $display("FAIL ff_fetch: got %b want 1", last_fetch); end
        checks++; if (last_addr !== 16'h0200) begin errors++; $display("FAIL ff_addr: got %h want 0200", last_addr); end
        checks++; if (bus_a.insn_valid !== 1'b0) begin errors++; $display("FAIL ff_stale_dropped: got %b want 0", bus_a.insn_valid); end
        tick(1, 0, '0, 0, 1);
        checks++; if (bus_a.insn_valid !== 1'b1) begin errors++; $display("FAIL ff_valid: got %b want 1", bus_a.insn_valid); end
        checks++; if (bus_a.insn_pc !== 16'h0200) begin errors++; $display("FAIL ff_pc: got %h want 0200", bus_a.insn_pc); end
        checks++; if (bus_a.insn !== 32'h0000_A8AA) begin errors++; $display("FAIL ff_data: got %h want 0000a8aa", bus_a.insn); end
    endtask

    task automatic test_full_toggle();
        do_reset();
        for (int i = 0; i < 40; i++) tick(((i % 2) == 0) ? 1'b1 : 1'b0, 0, '0, 1, 1);
        for (int i = 0; i < 10; i++) tick(0, 0, '0, 0, 1);
        checks++; if (pop_pc.size() !== nacks) begin errors++; $display("FAIL toggle_count: got %0d want %0d", pop_pc.size(), nacks); end
        for (int i = 0; i < pop_pc.size(); i++) begin
            checks++; if (pop_pc[i] !== ptr'(32'h100 + i)) begin errors++; $display("FAIL toggle_pc[%0d]: got %h want %h", i, pop_pc[i], ptr'(32'h100 + i)); end
            checks++; if (pop_data[i] !== exp_data(ptr'(32'h100 + i))) begin errors++; $display("FAIL toggle_data[%0d]: got %h want %h", i, pop_data[i], exp_data(ptr'(32'h100 + i))); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        checks++; if (bus_b.fetch !== 1'b1 || bus_b.addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_first_req: got %b/%h want 1/ffff", bus_b.fetch, bus_b.addr); end
        bus_b.fetch_ack = 1;
        @(negedge clk);
        bus_b.fetch_ack = bus_b.fetch;
        bus_b.fetched = 1; bus_b.fetch_data = exp_data(16'hFFFF);
        @(posedge clk); #1;
        checks++; if (bus_b.addr !== 16'h0001) begin errors++; $display("FAIL wrap_addr: got %h want 0001", bus_b.addr); end
        @(negedge clk);
        bus_b.fetch_ack = 0; bus_b.stall = 1;
        bus_b.fetched = 1; bus_b.fetch_data = exp_data(16'h0000);
        #1;
        checks++; if (bus_b.insn_pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_pc0: got %h want ffff", bus_b.insn_pc); end
        checks++; if (bus_b.insn !== 32'h0000_5555) begin errors++; $display("FAIL wrap_data0: got %h want 00005555", bus_b.insn); end
        @(negedge clk);
        bus_b.fetched = 0; bus_b.stall = 0;
        #1;
        checks++; if (bus_b.insn_pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_pc0_held: got %h want ffff", bus_b.insn_pc); end
        @(negedge clk);
        #1;
        checks++; if (bus_b.insn_valid !== 1'b1 || bus_b.insn_pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc1: got %b/%h want 1/0000", bus_b.insn_valid, bus_b.insn_pc); end
        checks++; if (bus_b.insn !== 32'h0000_AAAA) begin errors++; $display("FAIL wrap_data1: got %h want 0000aaaa", bus_b.insn); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_stream();
        test_stall_full();
        test_flush_pending();
        test_flush_fetched();
        test_full_toggle();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
